// File: rtl/lcd_pkg.sv
// Shared definitions for the text-LCD writer: HD44780 command bytes,
// top-level and bus-cycle state encodings, and small command helpers.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_DDRAM    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'h40;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_CMD_ADDR,
        ST_WR_DATA,
        ST_CLEAR
    } lcd_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SU,
        PH_PW,
        PH_HOLD,
        PH_WAIT
    } bus_phase_t;

    // Power-up command order; the last entry is the clear command.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Set-DDRAM-address command for a (row, column) position.
    function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] column);
        return LCD_DDRAM | (row ? LCD_LINE2 : 8'h00) | {4'h0, column};
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: SU (E low, RS/DATA set up), PW (E high),
// HOLD (E low, RS/DATA held), then WAIT for command execution.
// done is high in the last WAIT cycle; a start seen in that cycle chains
// the next bus cycle with no gap. RS/DATA change only on SU entry.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int T_SU   = 2,
    parameter int T_PW   = 10,
    parameter int T_HOLD = 2,
    parameter int T_EXEC = 50,
    parameter int T_CLR  = 2000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int MAX_T01 = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int MAX_T2  = (MAX_T01 > T_HOLD) ? MAX_T01 : T_HOLD;
    localparam int MAX_T3  = (MAX_T2 > T_EXEC) ? MAX_T2 : T_EXEC;
    localparam int MAX_T   = (MAX_T3 > T_CLR) ? MAX_T3 : T_CLR;
    // Sized from the longest phase, plus one bit of headroom.
    localparam int CNT_W   = $clog2(MAX_T + 1) + 1;

    bus_phase_t       phase;
    logic [CNT_W-1:0] cnt;
    logic             long_q;

    assign done = (phase == PH_WAIT) && (cnt == '0);

    // Phase sequencer; E is a flop so an asynchronous reset drops it at once.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (start && ((phase == PH_IDLE) || done)) begin
            phase    <= PH_SU;
            cnt      <= CNT_W'(T_SU - 1);
            long_q   <= long_wait;
            lcd_e    <= 1'b0;
            lcd_rs   <= rs;
            lcd_data <= data;
        end else begin
            case (phase)
                PH_SU: begin
                    if (cnt == '0) begin
                        phase <= PH_PW;
                        cnt   <= CNT_W'(T_PW - 1);
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PH_PW: begin
                    if (cnt == '0) begin
                        phase <= PH_HOLD;
                        cnt   <= CNT_W'(T_HOLD - 1);
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt == '0) begin
                        phase <= PH_WAIT;
                        cnt   <= long_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_EXEC - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PH_WAIT: begin
                    if (cnt == '0) begin
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    phase <= PH_IDLE;
                    lcd_e <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_text_writer.sv
// Text-LCD writer: runs the HD44780 power-up init, then turns accepted
// character-write and clear requests into bus cycles.
// Optional feature macro: LCD_ADDR_SKIP_EN -- when defined, a cursor
// tracker lets a write to the current cursor position skip the
// set-address command.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 20000,
    parameter int T_SU    = 2,
    parameter int T_PW    = 10,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 50,
    parameter int T_CLR   = 2000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       req,
    input  logic       clr,
    input  logic       line,
    input  logic [3:0] col,
    input  logic [7:0] char,
    output logic       ready,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int PWR_W = $clog2(T_PWRUP + 1);

    lcd_state_t       state, state_n;
    logic [1:0]       init_idx, idx_n;
    logic [PWR_W-1:0] pwr_cnt;
    logic [7:0]       char_q;
    logic             addr_hit;
    logic             bus_start, bus_rs, bus_long, bus_done;
    logic [7:0]       bus_data;

    assign ready  = (state == ST_IDLE);
    assign LCD_RW = 1'b0;

`ifdef LCD_ADDR_SKIP_EN
    logic       line_q;
    logic [3:0] col_q;
    logic       trk_valid;
    logic       trk_line;
    logic [3:0] trk_col;

    assign addr_hit = trk_valid && (trk_line == line) && (trk_col == col);

    // Cursor tracker: follows auto-increment, invalid after clear or end of row.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            line_q    <= 1'b0;
            col_q     <= 4'h0;
            trk_valid <= 1'b0;
            trk_line  <= 1'b0;
            trk_col   <= 4'h0;
        end else if (state == ST_IDLE && clr) begin
            trk_valid <= 1'b0;
        end else if (state == ST_IDLE && req) begin
            line_q <= line;
            col_q  <= col;
        end else if (state == ST_WR_DATA && bus_done) begin
            trk_valid <= (col_q != 4'hF);
            trk_line  <= line_q;
            trk_col   <= col_q + 4'd1;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    // State register, power-up delay and captured character.
    // NOTE: RESETN is an asynchronous active-high reset, hence posedge in the sensitivity list.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state    <= ST_PWRUP;
            init_idx <= 2'd0;
            pwr_cnt  <= PWR_W'(T_PWRUP - 1);
            char_q   <= 8'h00;
        end else begin
            state    <= state_n;
            init_idx <= idx_n;
            if (state == ST_PWRUP && pwr_cnt != '0) begin
                pwr_cnt <= pwr_cnt - 1'b1;
            end
            if (state == ST_IDLE && req && !clr) begin
                char_q <= char;
            end
        end
    end

    // Next state and the next command handed to the bus sequencer.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        idx_n     = init_idx;
        bus_start = 1'b0;
        bus_rs    = 1'b0;
        bus_data  = 8'h00;
        bus_long  = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (pwr_cnt == '0) begin
                    bus_start = 1'b1;
                    bus_data  = init_cmd(2'd0);
                    idx_n     = 2'd0;
                    state_n   = ST_INIT;
                end
            end
            ST_INIT: begin
                if (bus_done) begin
                    if (init_idx == 2'd3) begin
                        state_n = ST_IDLE;
                    end else begin
                        idx_n     = init_idx + 2'd1;
                        bus_start = 1'b1;
                        bus_data  = init_cmd(idx_n);
                        bus_long  = (bus_data == LCD_CLEAR);
                    end
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    bus_start = 1'b1;
                    bus_data  = LCD_CLEAR;
                    bus_long  = 1'b1;
                    state_n   = ST_CLEAR;
                end else if (req) begin
                    bus_start = 1'b1;
                    if (addr_hit) begin
                        bus_rs   = 1'b1;
                        bus_data = char;
                        state_n  = ST_WR_DATA;
                    end else begin
                        bus_data = ddram_addr(line, col);
                        state_n  = ST_CMD_ADDR;
                    end
                end
            end
            ST_CMD_ADDR: begin
                if (bus_done) begin
                    bus_start = 1'b1;
                    bus_rs    = 1'b1;
                    bus_data  = char_q;
                    state_n   = ST_WR_DATA;
                end
            end
            ST_WR_DATA, ST_CLEAR: begin
                if (bus_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_PWRUP;
        endcase
    end

    lcd_bus_cycle #(
        .T_SU  (T_SU),
        .T_PW  (T_PW),
        .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC),
        .T_CLR (T_CLR)
    ) u_bus (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .start    (bus_start),
        .rs       (bus_rs),
        .data     (bus_data),
        .long_wait(bus_long),
        .done     (bus_done),
        .lcd_e    (LCD_E),
        .lcd_rs   (LCD_RS),
        .lcd_data (LCD_DATA)
    );

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with default timing parameters.
// Expected bus traffic and ready latencies are hand-computed; the
// LCD_ADDR_SKIP_EN-dependent expectations follow the same macro.
module tb_lcd_text_writer;

    localparam int W      = 64;
    localparam int W_CLR  = 2014;
    localparam int T_INIT = 20000 + 3 * W + W_CLR;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       req = 1'b0;
    logic       clr = 1'b0;
    logic       line = 1'b0;
    logic [3:0] col = 4'h0;
    logic [7:0] char = 8'h00;
    logic       ready;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    int total = 0;
    int bad   = 0;

    // Each E pulse records {RS, DATA} at its rising edge and its width in cycles.
    logic [8:0] bus_q[$];
    int         width_q[$];
    int         width = 0;
    logic       prev_e = 1'b0;

    lcd_text_writer dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .req     (req),
        .clr     (clr),
        .line    (line),
        .col     (col),
        .char    (char),
        .ready   (ready),
        .LCD_E   (LCD_E),
        .LCD_RS  (LCD_RS),
        .LCD_RW  (LCD_RW),
        .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;

    // Bus monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (LCD_E === 1'b1 && prev_e !== 1'b1) bus_q.push_back({LCD_RS, LCD_DATA});
        if (LCD_E === 1'b1) begin
            width++;
        end else if (prev_e === 1'b1) begin
            width_q.push_back(width);
            width = 0;
        end
        prev_e = LCD_E;
    end

    task automatic clear_mon;
        bus_q.delete();
        width_q.delete();
    endtask

    // Returns the number of falling edges until ready is seen high (bounded).
    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic test_reset;
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        total++; if (LCD_E !== 1'b0)     begin bad++; $display("FAIL reset_e: got %b expected 0", LCD_E); end
        total++; if (LCD_RS !== 1'b0)    begin bad++; $display("FAIL reset_rs: got %b expected 0", LCD_RS); end
        total++; if (LCD_RW !== 1'b0)    begin bad++; $display("FAIL reset_rw: got %b expected 0", LCD_RW); end
        total++; if (LCD_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", LCD_DATA); end
        total++; if (ready !== 1'b0)     begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        RESETN = 1'b0;
        clear_mon();
    endtask

    // Called right after RESETN is released on a falling edge.
    task automatic test_init(input string name);
        logic [8:0] exp_cmd[4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
        int n;
        @(negedge CLK);
        wait_ready(T_INIT + 1000, n);
        total++;
        if (n + 1 != T_INIT) begin
            bad++; $display("FAIL %s_latency: got %0d expected %0d", name, n + 1, T_INIT);
        end
        total++;
        if (bus_q.size() != 4) begin
            bad++; $display("FAIL %s_count: got %0d expected 4", name, bus_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (bus_q[i] !== exp_cmd[i]) begin
                    bad++; $display("FAIL %s_cmd%0d: got %h expected %h", name, i, bus_q[i], exp_cmd[i]);
                end
            end
        end
        foreach (width_q[i]) begin
            total++;
            if (width_q[i] != 10) begin
                bad++; $display("FAIL %s_width%0d: got %0d expected 10", name, i, width_q[i]);
            end
        end
    endtask

    // Presents one request in the current cycle (ready expected high) and
    // checks ready drop, ready-return latency and the bus traffic.
    task automatic run_request(input string name, input logic r, input logic c,
                               input logic ln, input logic [3:0] cl, input logic [7:0] ch,
                               input int exp_lat, input int n_exp,
                               input logic [8:0] e0, input logic [8:0] e1);
        logic [8:0] exp_bus[2];
        int n;
        exp_bus[0] = e0;
        exp_bus[1] = e1;
        total++;
        if (ready !== 1'b1) begin
            bad++; $display("FAIL %s_ready_before: got %b expected 1", name, ready);
        end
        clear_mon();
        req  = r;
        clr  = c;
        line = ln;
        col  = cl;
        char = ch;
        @(posedge CLK);
        #1;
        req  = 1'b0;
        clr  = 1'b0;
        line = 1'b0;
        col  = 4'h0;
        char = 8'hFF;
        @(negedge CLK);
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL %s_ready_drop: got %b expected 0", name, ready);
        end
        wait_ready(5000, n);
        total++;
        if (n != exp_lat) begin
            bad++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat);
        end
        total++;
        if (bus_q.size() != n_exp) begin
            bad++; $display("FAIL %s_count: got %0d expected %0d", name, bus_q.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                total++;
                if (bus_q[i] !== exp_bus[i]) begin
                    bad++; $display("FAIL %s_bus%0d: got %h expected %h", name, i, bus_q[i], exp_bus[i]);
                end
            end
        end
        foreach (width_q[i]) begin
            total++;
            if (width_q[i] != 10) begin
                bad++; $display("FAIL %s_width%0d: got %0d expected 10", name, i, width_q[i]);
            end
        end
    endtask

    task automatic test_char_write;
        run_request("char_a", 1'b1, 1'b0, 1'b0, 4'd3, 8'h41, 2 * W, 2, 9'h083, 9'h141);
    endtask

    task automatic test_next_char;
`ifdef LCD_ADDR_SKIP_EN
        run_request("char_b", 1'b1, 1'b0, 1'b0, 4'd4, 8'h42, W, 1, 9'h142, 9'h000);
`else
        run_request("char_b", 1'b1, 1'b0, 1'b0, 4'd4, 8'h42, 2 * W, 2, 9'h084, 9'h142);
`endif
    endtask

    task automatic test_wrap;
        run_request("col15", 1'b1, 1'b0, 1'b1, 4'd15, 8'h43, 2 * W, 2, 9'h0CF, 9'h143);
        run_request("col0",  1'b1, 1'b0, 1'b1, 4'd0,  8'h44, 2 * W, 2, 9'h0C0, 9'h144);
    endtask

    task automatic test_clr_priority;
        run_request("clr_req", 1'b1, 1'b1, 1'b1, 4'd1, 8'h5A, W_CLR, 1, 9'h001, 9'h000);
        // Tracker was (1,1) before the clear; the clear must force an address command.
        run_request("after_clr", 1'b1, 1'b0, 1'b1, 4'd1, 8'h45, 2 * W, 2, 9'h0C1, 9'h145);
    endtask

    task automatic test_back_to_back;
`ifdef LCD_ADDR_SKIP_EN
        run_request("b2b", 1'b1, 1'b0, 1'b1, 4'd2, 8'h46, W, 1, 9'h146, 9'h000);
`else
        run_request("b2b", 1'b1, 1'b0, 1'b1, 4'd2, 8'h46, 2 * W, 2, 9'h0C2, 9'h146);
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        req  = 1'b1;
        line = 1'b0;
        col  = 4'd0;
        char = 8'h47;
        @(posedge CLK);
        #1;
        req = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!(LCD_E === 1'b1 && LCD_RS === 1'b1) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++; $display("FAIL midrst_find_pw: got timeout expected data pulse");
        end
        repeat (3) @(negedge CLK);
        #2;
        RESETN = 1'b1;
        #1;
        total++; if (LCD_E !== 1'b0)     begin bad++; $display("FAIL midrst_e: got %b expected 0", LCD_E); end
        total++; if (LCD_RS !== 1'b0)    begin bad++; $display("FAIL midrst_rs: got %b expected 0", LCD_RS); end
        total++; if (LCD_DATA !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h expected 00", LCD_DATA); end
        total++; if (ready !== 1'b0)     begin bad++; $display("FAIL midrst_ready: got %b expected 0", ready); end
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        clear_mon();
        test_init("reinit");
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_char_write();
        test_next_char();
        test_wrap();
        test_clr_priority();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
